// File: rtl/eth_arb_pkg.sv
// eth_arb_pkg: shared types, widths and round-robin helper for the Ethernet TX arbiter.
package eth_arb_pkg;
   typedef enum logic [1:0] {IDLE, XFER, FLUSH} arb_state_t;
   localparam int ETH_BYTE_W = 8;
   // First requester after ptr, wrapping at n; returns ptr when nobody requests.
   function automatic logic [2:0] rr_select(input logic [7:0] req, input logic [2:0] ptr, input int n);
      rr_select = ptr;
      for (int k = 8; k >= 1; k--)
         if (k <= n && req[(int'(ptr) + k) % n]) rr_select = 3'((int'(ptr) + k) % n);
   endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: registered 2-entry AXI-Stream buffer carrying tdata/tlast/tuser.
// Upstream ready depends only on occupancy, so downstream ready never reaches the source combinationally.
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_125,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   input  logic                  s_tuser,
   output logic                  s_trdy,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   output logic                  m_tuser,
   input  logic                  m_trdy
);
   logic [DATA_WIDTH+1:0] head, tail, beat;
   logic [1:0] count;
   logic push, pop;
   assign beat = {s_tuser, s_tlast, s_tdata};
   assign s_trdy = count != 2'd2;
   assign m_tvalid = count != 2'd0;
   assign {m_tuser, m_tlast, m_tdata} = head;
   assign push = s_tvalid & s_trdy;
   assign pop = m_tvalid & m_trdy;
   always_ff @(posedge clk_125) begin
      if (!reset_n) begin
         head <= '0;
         tail <= '0;
         count <= '0;
      end else begin
         if (pop && count == 2'd2) head <= tail;
         else if (push && (count == 2'd0 || pop)) head <= beat;
         if (push && !pop && count == 2'd1) tail <= beat;
         count <= count + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-granular round-robin mux of NUM_PORTS AXI-Stream sources onto the MAC TX stream.
// Define ETH_TX_ARB_TIMEOUT_EN to terminate and flush packets whose source stalls for TIMEOUT_CYCLES.
module eth_tx_arbiter
   import eth_arb_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int DATA_WIDTH     = ETH_BYTE_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk_125,
   input  logic                            reset_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   input  logic [NUM_PORTS-1:0]            s_axis_tuser,
   output logic [NUM_PORTS-1:0]            s_axis_trdy,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tuser,
   input  logic                            m_axis_trdy,
   output logic [$clog2(NUM_PORTS)-1:0]    grant_idx,
   output logic                            busy,
   output logic [15:0]                     pkt_count
);
   localparam int GW = $clog2(NUM_PORTS);
   if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("eth_tx_arbiter: unsupported parameter set");
   end
   arb_state_t state, state_nx;
   logic [GW-1:0] ptr;
   logic buf_rdy, push, push_last, push_user, g_valid, g_last;
   logic [DATA_WIDTH-1:0] push_data;
   assign g_valid = s_axis_tvalid[grant_idx];
   assign g_last = s_axis_tlast[grant_idx];
   assign busy = state != IDLE;
`ifdef ETH_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo;
   always_ff @(posedge clk_125) begin
      if (!reset_n || state != XFER || push) tmo <= '0;
      else if (!g_valid && tmo != TW'(TIMEOUT_CYCLES)) tmo <= tmo + 1'b1;
   end
`endif
   always_comb begin
      state_nx = state;
      s_axis_trdy = '0;
      push = 1'b0;
      push_data = s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      push_last = g_last;
      push_user = s_axis_tuser[grant_idx];
      case (state)
         IDLE: if (|s_axis_tvalid) state_nx = XFER;
         XFER: begin
`ifdef ETH_TX_ARB_TIMEOUT_EN
            if (tmo == TW'(TIMEOUT_CYCLES)) begin
               push = buf_rdy;
               push_data = '0;
               push_last = 1'b1;
               push_user = 1'b1;
               if (buf_rdy) state_nx = FLUSH;
            end else
`endif
            begin
               s_axis_trdy[grant_idx] = buf_rdy;
               push = g_valid & buf_rdy;
               if (push && g_last) state_nx = IDLE;
            end
         end
`ifdef ETH_TX_ARB_TIMEOUT_EN
         FLUSH: begin
            s_axis_trdy[grant_idx] = 1'b1;
            if (g_valid && g_last) state_nx = IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_125) begin
      if (!reset_n) begin
         state <= IDLE;
         grant_idx <= '0;
         ptr <= GW'(NUM_PORTS - 1);
         pkt_count <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx == XFER)
            grant_idx <= GW'(rr_select(8'(s_axis_tvalid), 3'(ptr), NUM_PORTS));
         if (state != IDLE && state_nx == IDLE) ptr <= grant_idx;
         if (m_axis_tvalid && m_axis_trdy && m_axis_tlast) pkt_count <= pkt_count + 1'b1;
      end
   end
   axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk_125(clk_125),
      .reset_n(reset_n),
      .s_tdata(push_data),
      .s_tvalid(push),
      .s_tlast(push_last),
      .s_tuser(push_user),
      .s_trdy(buf_rdy),
      .m_tdata(m_axis_tdata),
      .m_tvalid(m_axis_tvalid),
      .m_tlast(m_axis_tlast),
      .m_tuser(m_axis_tuser),
      .m_trdy(m_axis_trdy)
   );
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed self-checking bench for eth_tx_arbiter with two byte-wide sources.
// With ETH_TX_ARB_TIMEOUT_EN defined the stall step exercises the starvation flush instead of the held grant.
module tb_eth_tx_arbiter;
   localparam int NP = 2;
   localparam int DW = 8;
   logic clk_125 = 1'b0;
   logic reset_n = 1'b0;
   logic [NP*DW-1:0] s_axis_tdata = '0;
   logic [NP-1:0] s_axis_tvalid = '0;
   logic [NP-1:0] s_axis_tlast = '0;
   logic [NP-1:0] s_axis_tuser = '0;
   logic [NP-1:0] s_axis_trdy;
   logic [DW-1:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tlast, m_axis_tuser;
   logic m_axis_trdy = 1'b1;
   logic [0:0] grant_idx;
   logic busy;
   logic [15:0] pkt_count;
   int checks = 0, failures = 0;
   int cyc = 0, first_cyc = 0, occ = 0, stable_err = 0, trdy_err = 0;
   logic saw_full = 1'b0, chk_trdy = 1'b0, held_v = 1'b0, busy_d = 1'b0, bp = 1'b0;
   logic [9:0] held = '0;
   logic [NP-1:0] stall = '0;
   logic [9:0] q0[$], q1[$], out_q[$], exp_q[$];
   logic [0:0] grant_q[$];

   eth_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
      .clk_125(clk_125),
      .reset_n(reset_n),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser(s_axis_tuser),
      .s_axis_trdy(s_axis_trdy),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser),
      .m_axis_trdy(m_axis_trdy),
      .grant_idx(grant_idx),
      .busy(busy),
      .pkt_count(pkt_count)
   );

   always #4 clk_125 = ~clk_125;
   always @(posedge clk_125) cyc++;

   // Output capture, stability, ready-vs-occupancy and grant logging, all sampled mid-cycle.
   always @(negedge clk_125) begin
      if (!reset_n) begin
         occ = 0;
         held_v = 1'b0;
         busy_d = 1'b0;
      end else begin
         if (held_v && (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== held)) stable_err++;
         held_v = m_axis_tvalid && !m_axis_trdy;
         held = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
         if (chk_trdy && busy && (s_axis_trdy[grant_idx] !== (occ < 2))) trdy_err++;
         if (occ == 2) saw_full = 1'b1;
         occ = occ + ((|(s_axis_tvalid & s_axis_trdy)) ? 1 : 0) - ((m_axis_tvalid && m_axis_trdy) ? 1 : 0);
         if (m_axis_tvalid && m_axis_trdy) begin
            if (out_q.size() == 0) first_cyc = cyc;
            out_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
         end
         if (busy && !busy_d) grant_q.push_back(grant_idx);
         busy_d = busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [NP-1:0] acc;
      s_axis_tvalid[0] = q0.size() > 0 && !stall[0];
      s_axis_tvalid[1] = q1.size() > 0 && !stall[1];
      {s_axis_tuser[0], s_axis_tlast[0], s_axis_tdata[7:0]} = q0.size() > 0 ? q0[0] : 10'h0;
      {s_axis_tuser[1], s_axis_tlast[1], s_axis_tdata[15:8]} = q1.size() > 0 ? q1[0] : 10'h0;
      m_axis_trdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_125);
      acc = s_axis_tvalid & s_axis_trdy;
      @(posedge clk_125);
      #1;
      if (acc[0]) void'(q0.pop_front());
      if (acc[1]) void'(q1.pop_front());
   endtask

   task automatic load(input int port, input int n, input logic [7:0] base, input logic usr, input logic to_exp);
      logic [9:0] b;
      for (int i = 0; i < n; i++) begin
         b = {usr && (i == n - 1), i == n - 1, 8'(base + 8'(i))};
         if (port == 0) q0.push_back(b);
         else q1.push_back(b);
         if (to_exp) exp_q.push_back(b);
      end
   endtask

   task automatic run_until(input string tag, input int n, input int budget);
      int k = 0;
      while (out_q.size() < n && k < budget) begin
         step();
         k++;
      end
      chk(tag, out_q.size(), n);
   endtask

   task automatic cmp_out(input string tag);
      int bad = 0;
      if (out_q.size() != exp_q.size()) bad++;
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         if (out_q[i] !== exp_q[i]) bad++;
      chk(tag, bad, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q0.delete();
      q1.delete();
      stall = '0;
      bp = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      out_q.delete();
      exp_q.delete();
      grant_q.delete();
   endtask

   initial begin
      int c0;
      logic [3:0] gs;
      @(posedge clk_125);
      #1;
      do_reset();
      chk("rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_tdata", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 0);
      chk("rst_trdy", 32'(s_axis_trdy), 0);
      chk("rst_grant", 32'(grant_idx), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pkt_count", 32'(pkt_count), 0);

      load(0, 64, 8'h00, 1'b0, 1'b1);
      c0 = cyc;
      run_until("single_count", 64, 200);
      cmp_out("single_data");
      chk("single_latency", first_cyc - c0, 2);
      step();
      chk("single_pkt_count", 32'(pkt_count), 1);

      do_reset();
      load(0, 10, 8'h10, 1'b0, 1'b1);
      load(1, 10, 8'h90, 1'b0, 1'b1);
      load(0, 10, 8'h20, 1'b0, 1'b1);
      load(1, 10, 8'hA0, 1'b0, 1'b1);
      run_until("rr_count", 40, 300);
      cmp_out("rr_order");
      gs = {grant_q[0], grant_q[1], grant_q[2], grant_q[3]};
      chk("rr_grant_seq", 32'(gs), 32'h5);
      chk("rr_pkt_count", 32'(pkt_count), 4);

      do_reset();
      bp = 1'b1;
      chk_trdy = 1'b1;
      saw_full = 1'b0;
      load(1, 100, 8'h40, 1'b0, 1'b1);
      run_until("bp_count", 100, 800);
      cmp_out("bp_data");
      chk("bp_stable", stable_err, 0);
      chk("bp_trdy_vs_full", trdy_err, 0);
      chk("bp_saw_full", 32'(saw_full), 1);
      bp = 1'b0;
      chk_trdy = 1'b0;
      step();
      chk("bp_pkt_count", 32'(pkt_count), 1);

      do_reset();
      load(0, 1, 8'hAA, 1'b0, 1'b1);
      load(1, 1, 8'h55, 1'b1, 1'b1);
      run_until("beat_count", 2, 40);
      cmp_out("beat_data");
      step();
      chk("beat_pkt_count", 32'(pkt_count), 2);

      do_reset();
      load(0, 1, 8'h01, 1'b0, 1'b0);
      load(0, 20, 8'h60, 1'b0, 1'b0);
      for (int k = 0; k < 100 && q0.size() > 15; k++) step();
      chk("mid_reached", q0.size(), 15);
      chk("mid_pre_count", 32'(pkt_count), 1);
      reset_n = 1'b0;
      q0.delete();
      step();
      chk("mid_tvalid", 32'(m_axis_tvalid), 0);
      chk("mid_trdy", 32'(s_axis_trdy), 0);
      chk("mid_pkt_count", 32'(pkt_count), 0);
      reset_n = 1'b1;
      out_q.delete();
      grant_q.delete();
      exp_q.delete();
      load(0, 1, 8'h21, 1'b0, 1'b1);
      load(1, 1, 8'h31, 1'b0, 1'b1);
      run_until("mid_after_count", 2, 40);
      cmp_out("mid_after_order");
      chk("mid_first_grant", 32'(grant_q[0]), 0);

`ifndef ETH_TX_ARB_TIMEOUT_EN
      do_reset();
      load(0, 6, 8'hC0, 1'b0, 1'b1);
      for (int k = 0; k < 100 && q0.size() > 3; k++) step();
      stall[0] = 1'b1;
      load(1, 4, 8'hD0, 1'b0, 1'b1);
      repeat (20) step();
      chk("stall_grant", 32'(grant_idx), 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_other_trdy", 32'(s_axis_trdy[1]), 0);
      chk("stall_out", out_q.size(), 3);
      stall[0] = 1'b0;
      run_until("stall_count", 10, 60);
      cmp_out("stall_order");
      chk("stall_pkt_count", 32'(pkt_count), 2);
`else
      do_reset();
      load(1, 8, 8'hE0, 1'b0, 1'b0);
      for (int k = 0; k < 100 && q1.size() > 5; k++) step();
      stall[1] = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 8'(8'hE0 + 8'(i))});
      exp_q.push_back(10'h300);
      load(0, 1, 8'h01, 1'b0, 1'b1);
      repeat (30) step();
      chk("tmo_out", out_q.size(), 4);
      chk("tmo_busy", 32'(busy), 1);
      stall[1] = 1'b0;
      run_until("tmo_count", 5, 60);
      cmp_out("tmo_order");
      chk("tmo_discarded", q1.size(), 0);
      chk("tmo_grant", 32'(grant_idx), 0);
      chk("tmo_pkt_count", 32'(pkt_count), 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single Ethernet MAC TX AXI-Stream input (8-bit, clk_125 domain) between NUM_PORTS upstream packet sources (e.g. UDP/IP stack, ARP responder).
- Packet-granular round-robin: a grant is held from the first beat to the tlast beat, so frames never interleave.
- Output passes through a registered 2-entry skid buffer, so the MAC's s_tx_axis_trdy never combinationally reaches the sources.

Parameters:
- NUM_PORTS, 2, number of requesting AXI-Stream sources (2..8).
- DATA_WIDTH, 8, byte width of every stream.
- TIMEOUT_CYCLES, 1024, mid-packet starvation limit (used only with the optional feature).

Ports:
- clk_125  in  1  125 MHz system clock.
- reset_n  in  1  synchronous, active-low reset, sampled on clk_125.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  per-source data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_PORTS  per-source valid.
- s_axis_tlast  in  NUM_PORTS  per-source last beat.
- s_axis_tuser  in  NUM_PORTS  per-source error flag; forwarded unchanged.
- s_axis_trdy  out  NUM_PORTS  per-source ready.
- m_axis_tdata  out  DATA_WIDTH  data to the MAC TX.
- m_axis_tvalid  out  1  valid to the MAC TX.
- m_axis_tlast  out  1  last beat to the MAC TX.
- m_axis_tuser  out  1  error flag to the MAC TX.
- m_axis_trdy  in  1  ready from the MAC TX.
- grant_idx  out  $clog2(NUM_PORTS)  currently or last granted source.
- busy  out  1  high while a packet is locked.
- pkt_count  out  16  count of completed output packets.

Behaviour:
- Reset (reset_n=0 at a clk_125 edge):
  - m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0.
  - s_axis_trdy=0, grant_idx=0, busy=0, pkt_count=0.
  - Round-robin pointer=NUM_PORTS-1, so port 0 wins first.
  - Skid buffer is flushed.
- Reset mid-packet: the partial frame is dropped without tlast. Frame integrity across reset is the MAC's responsibility.
- States:
  - IDLE: if any s_axis_tvalid is high, select the first requester searching from pointer+1 modulo NUM_PORTS. Register grant_idx, set busy=1, go to XFER. Arbitration decision costs 1 cycle. All s_axis_trdy=0 in IDLE.
  - XFER:
    - s_axis_trdy[grant_idx] = skid buffer not full. All other bits are 0.
    - Each accepted beat enters the skid buffer. It appears on m_axis the cycle after acceptance (1-cycle latency).
    - When a tlast beat is accepted: pointer<=grant_idx, busy<=0, go to IDLE.
    - Minimum inter-packet bubble at the input is 1 cycle. The output may stay continuous if the buffer holds data.
  - FLUSH: exists only with the optional feature (see below).
- Skid buffer:
  - 2 entries; full when 2 beats are held.
  - m_axis_tvalid=1 whenever occupancy is nonzero. Head is presented on m_axis.
  - Simultaneous push and pop keeps occupancy constant.
  - m_axis_tdata/tlast/tuser stay stable while tvalid=1 and trdy=0.
- Source stall: the granted source's tvalid may drop mid-packet. The grant is held; other sources wait.
- Single-beat packet (tvalid and tlast in the same beat) is legal: IDLE→XFER→IDLE.
- pkt_count increments on each m_axis tvalid&trdy&tlast. It wraps 0xFFFF→0x0000.
- grant_idx holds its value in IDLE until the next grant.

Optional Feature:
- Macro: ETH_TX_ARB_TIMEOUT_EN.
- Defined:
  - In XFER, a counter increments on each cycle where the granted tvalid=0, and clears on each accepted beat.
  - At TIMEOUT_CYCLES, push a terminating beat (tdata=0, tlast=1, tuser=1) into the skid buffer when there is space, then enter FLUSH.
  - FLUSH: s_axis_trdy[grant_idx]=1; beats are discarded. On the discarded tlast, update pointer, set busy=0, go to IDLE.
- Not defined: no counter, no FLUSH state; a stalled source holds the grant indefinitely.

Decomposition:
- Package eth_arb_pkg holds:
  - arb_state_t enum {IDLE, XFER, FLUSH}.
  - ETH_BYTE_W=8.
  - Function rr_select(req, ptr), returning the next index.
- One sub-module, axis_skid_buffer (parameter DATA_WIDTH; carries tdata/tlast/tuser), reusable on the RX path.

Test Plan:
- Single source: port 0 sends a 64-byte packet 0x00..0x3F with m_axis_trdy=1 → identical bytes on m_axis, tlast on 0x3F, first byte 2 cycles after port 0 tvalid rises, pkt_count=1.
- Contention: both ports hold 10-byte packets from reset → order port0, port1, port0, port1; no interleaving; grant_idx toggles after each tlast.
- Backpressure: random m_axis_trdy at 50% during a 100-byte packet → no loss or duplication; output fields stable while stalled; s_axis_trdy drops only when the buffer holds 2 beats.
- Single-beat packets: both ports send 1-byte packets (0xAA, 0x55) back-to-back → output AA(tlast), 55(tlast); pkt_count=2.
- Reset mid-packet: assert reset_n=0 after byte 5 of 20 → next cycle m_axis_tvalid=0, s_axis_trdy=0, pkt_count=0; next grant goes to port 0.
- ETH_TX_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: port 1 stalls 16 cycles after 3 bytes → output beat 0x00 with tlast=1, tuser=1; port 1's remaining bytes are discarded; port 0 is then granted.
